multu_hilo: RTL
===============

MULTU_HILO -- requirements
Module: multu_hilo

Interface
REQ-001 Parameter: FUNCT_MULTU, 6'b011001, funct code that starts an unsigned multiply.
REQ-002 Parameter: ITER, 32, number of shift-add iterations (equals operand width).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: dataA  input  32  multiplicand (unsigned).
REQ-006 Port: dataB  input  32  multiplier (unsigned).
REQ-007 Port: Signal  input  6  funct code of the current instruction.
REQ-008 Port: busy  output  1  high while a multiply is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when HiOut/LoOut have just been updated.
REQ-010 Port: HiOut  output  32  HI register, upper 32 bits of the last completed product.
REQ-011 Port: LoOut  output  32  LO register, lower 32 bits of the last completed product.

Function
REQ-012 States: IDLE, RUN, DONE; all are registered with a 6-bit iteration counter.
REQ-013 Start is accepted only in IDLE or DONE, at a rising edge where Signal == FUNCT_MULTU.
- dataA/dataB are captured into internal registers.
- The counter is cleared.
- State goes to RUN.
REQ-014 Operands are used only from the internal copies; changes to dataA/dataB/Signal after capture have no effect.
REQ-015 Each RUN cycle performs one shift-add step:
- If the multiplier LSB is 1, add the multiplicand to the upper 32 bits of a 64-bit accumulator, keeping the 33-bit carry.
- Shift the {carry, accumulator} right by 1.
- Increment the counter.
REQ-016 After the ITER-th RUN edge:
- The 64-bit accumulator is written to {HiOut, LoOut}.
- State goes to DONE.
REQ-017 Latency: start captured at edge N; HiOut/LoOut are valid and done=1 after edge N+32.
REQ-018 busy is 1 exactly in RUN and 0 in IDLE/DONE; done is 1 exactly in DONE.
REQ-019 DONE lasts one cycle. It exits to RUN if a new start is accepted at that edge, otherwise to IDLE.
REQ-020 Signal == FUNCT_MULTU while in RUN is ignored: no restart, no operand recapture.
REQ-021 HiOut/LoOut change only at the completion edge (REQ-016). During RUN they hold the previous product.
REQ-022 All other Signal values (including MFHI 6'b010000 and MFLO 6'b010010) cause no state change; HiOut/LoOut are continuously readable.
REQ-023 The product is exact 64-bit unsigned; no overflow or truncation is possible.

Reset
REQ-024 rst_n low asynchronously forces the following, in any state including mid-RUN:
- state = IDLE, counter = 0, internal operands/accumulator = 0.
- HiOut = 0, LoOut = 0, busy = 0, done = 0.
REQ-025 A multiply interrupted by reset is discarded; no partial result reaches HiOut/LoOut.
REQ-026 The first start is accepted at the first rising edge with rst_n high and Signal == FUNCT_MULTU.

Verification
REQ-027 Basic multiply: A=3, B=5, Signal=MULTU for one cycle.
- busy=1 for 32 cycles, then done=1.
- HiOut=0x00000000, LoOut=0x0000000F.
REQ-028 Maximum operands: A=B=0xFFFFFFFF.
- HiOut=0xFFFFFFFE, LoOut=0x00000001 (exercises carry-out handling).
REQ-029 Carry into HI: A=0x80000000, B=2 -> HiOut=0x00000001, LoOut=0x00000000.
REQ-030 Ignored restart and operand changes:
- Start A=7, B=6.
- At RUN cycle 10, drive Signal=MULTU with A=B=1.
- Result is HiOut=0, LoOut=42 at the original latency; prior HiOut/LoOut are held throughout RUN.
REQ-031 Reset mid-operation:
- Complete 2*2 (LoOut=4).
- Start 9*9, pulse rst_n low at RUN cycle 15.
- HiOut=LoOut=0 and busy=0 immediately; no done pulse follows.
REQ-032 Back-to-back starts:
- Start 4*4, then assert MULTU with A=10, B=10 in the DONE cycle.
- LoOut=16 with done=1; busy=1 on the next edge; LoOut=100 after 32 more cycles.

Source files
------------

// File: rtl/multu_hilo.sv
// Unsigned 32x32 -> 64 multiplier for the HI/LO register pair.
// One shift-add step per RUN cycle; HI/LO change only when a product completes.
module multu_hilo #(
    parameter logic [5:0] FUNCT_MULTU = 6'b011001,
    parameter int         ITER        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic        busy,
    output logic        done,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;

    logic        w_start;
    logic        w_last;
    logic [32:0] w_sum;
    logic [63:0] w_acc_next;

    assign w_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && (Signal == FUNCT_MULTU);
    assign w_last  = (r_cnt == 6'(ITER - 1));

    // One shift-add step: conditional add into the upper half, then shift {carry, acc} right
    always_comb begin
        w_sum      = {1'b0, r_acc[63:32]} + (r_mplier[0] ? {1'b0, r_mcand} : 33'd0);
        w_acc_next = {w_sum, r_acc[31:1]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = w_start ? S_RUN : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_next = w_start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Operand capture, iteration datapath and HI/LO result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            HiOut    <= '0;
            LoOut    <= '0;
        end else if (w_start) begin
            r_cnt    <= '0;
            r_mcand  <= dataA;
            r_mplier <= dataB;
            r_acc    <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt    <= r_cnt + 6'd1;
            r_mplier <= {1'b0, r_mplier[31:1]};
            r_acc    <= w_acc_next;
            if (w_last) begin
                HiOut <= w_acc_next[63:32];
                LoOut <= w_acc_next[31:0];
            end
        end
    end

endmodule
